// File: rtl/mvd_pkg.sv
// mvd_pkg: shared constants and types for the MVD motion-vector stage.
package mvd_pkg;

    localparam int MV_W        = 20;
    localparam int PIC_X_WIDTH = 6;
    localparam int LCU_GRID    = 8;

    localparam logic [1:0] MV_ADDR_NONE = 2'b00;
    localparam logic [1:0] MV_ADDR_NBR  = 2'b01;
    localparam logic [1:0] MV_ADDR_CUR  = 2'b10;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FILL   = 2'd1;
    localparam logic [1:0] ST_UPDATE = 2'd2;

    typedef struct packed {
        logic [2:0] bx0;
        logic [2:0] by0;
        logic [3:0] nbx;
        logic [3:0] nby;
    } pu_desc_t;

    // Number of 8x8 blocks spanned by a PU edge; sub-8 edges still cover one block.
    function automatic logic [3:0] blk_cnt(input logic [3:0] blocks);
        return (blocks == 4'd0) ? 4'd1 : blocks;
    endfunction

endpackage

// File: rtl/mvd_mv_buf_walk.sv
// mvd_mv_buf_walk: raster walker over the 8x8 blocks of one PU, x fastest.
module mvd_mv_buf_walk
    import mvd_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       start_i,
    input  logic       adv_i,
    input  pu_desc_t   desc_i,
    output logic [2:0] x_o,
    output logic [2:0] y_o,
    output logic       last_o
);

    pu_desc_t   desc_q, desc_d;
    logic [2:0] cx_q, cx_d;
    logic [2:0] cy_q, cy_d;
    logic       x_end;

    always_comb begin
        x_end  = ({1'b0, cx_q} == (desc_q.nbx - 4'd1));
        x_o    = desc_q.bx0 + cx_q;
        y_o    = desc_q.by0 + cy_q;
        last_o = x_end && ({1'b0, cy_q} == (desc_q.nby - 4'd1));

        desc_d = desc_q;
        cx_d   = cx_q;
        cy_d   = cy_q;
        if (start_i) begin
            desc_d = desc_i;
            cx_d   = 3'd0;
            cy_d   = 3'd0;
        end else if (adv_i) begin
            if (x_end) begin
                cx_d = 3'd0;
                cy_d = cy_q + 3'd1;
            end else begin
                cx_d = cx_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            desc_q <= '0;
            cx_q   <= 3'd0;
            cy_q   <= 3'd0;
        end else begin
            desc_q <= desc_d;
            cx_q   <= cx_d;
            cy_q   <= cy_d;
        end
    end

endmodule

// File: rtl/mvd_mv_buf.sv
// mvd_mv_buf: MV neighbour store (current LCU, left column, frame top line).
// Define MVD_MV_BUF_FWD_EN to forward a same-cycle FILL write to both read ports.
module mvd_mv_buf
    import mvd_pkg::*;
#(
    parameter int MV_W      = mvd_pkg::MV_W,
    parameter int CTU_X_MAX = 64
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start_i,
    input  logic [PIC_X_WIDTH-1:0] mb_x_i,
    input  logic                   wr_val_i,
    output logic                   wr_rdy_o,
    input  logic [5:0]             pos_x_i,
    input  logic [5:0]             pos_y_i,
    input  logic [6:0]             pu_width_i,
    input  logic [6:0]             pu_height_i,
    input  logic [MV_W-1:0]        wr_mv_i,
    output logic                   wr_done_o,
    input  logic                   upd_i,
    output logic                   busy_o,
    input  logic                   rd_en_i,
    input  logic [7:0]             a_addr_i,
    input  logic [8:0]             b_addr_i,
    output logic [MV_W-1:0]        a_mv_o,
    output logic [MV_W-1:0]        b_mv_o,
    output logic                   a_valid_o,
    output logic                   b_valid_o
);

    localparam int TOP_N  = LCU_GRID * CTU_X_MAX;
    localparam int TOP_AW = $clog2(TOP_N);
    localparam int TOP_IW = PIC_X_WIDTH + 4;
    localparam logic [TOP_IW-1:0] TOP_LIM = TOP_IW'(TOP_N);

    logic [1:0]             state_q, state_d;
    logic [PIC_X_WIDTH-1:0] mb_x_q, mb_x_d;
    logic [2:0]             upd_k_q, upd_k_d;
    logic [MV_W-1:0]        mv_q, mv_d;
    logic [MV_W-1:0]        a_mv_q, a_mv_d, b_mv_q, b_mv_d;
    logic                   a_valid_q, a_valid_d, b_valid_q, b_valid_d;

    logic [MV_W-1:0]        cur_q  [LCU_GRID][LCU_GRID];
    logic [MV_W-1:0]        left_q [LCU_GRID];
    logic [MV_W-1:0]        top_q  [TOP_N];

    logic                   fill, updating, wr_acc, walk_last;
    logic [2:0]             walk_x, walk_y;
    pu_desc_t               pu_desc;
    logic [TOP_IW-1:0]      upd_top_idx, b_top_idx;
    logic [MV_W-1:0]        a_cur_mv, b_cur_mv, a_rd_mv, b_rd_mv;
    logic                   a_rd_vld, b_rd_vld;
    logic                   unused_lsbs;

    assign unused_lsbs = ^{pos_x_i[2:0], pos_y_i[2:0], pu_width_i[2:0], pu_height_i[2:0]};

    mvd_mv_buf_walk u_walk (
        .clk     (clk),
        .rstn    (rstn),
        .start_i (wr_acc),
        .adv_i   (fill),
        .desc_i  (pu_desc),
        .x_o     (walk_x),
        .y_o     (walk_y),
        .last_o  (walk_last)
    );

    always_comb begin
        fill        = (state_q == ST_FILL);
        updating    = (state_q == ST_UPDATE);
        wr_rdy_o    = (state_q == ST_IDLE) && !upd_i;
        wr_acc      = wr_val_i && wr_rdy_o;
        wr_done_o   = fill && walk_last;
        busy_o      = fill || updating;

        pu_desc.bx0 = pos_x_i[5:3];
        pu_desc.by0 = pos_y_i[5:3];
        pu_desc.nbx = blk_cnt(pu_width_i[6:3]);
        pu_desc.nby = blk_cnt(pu_height_i[6:3]);

        state_d = state_q;
        mb_x_d  = mb_x_q;
        upd_k_d = upd_k_q;
        mv_d    = wr_acc ? wr_mv_i : mv_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) mb_x_d = mb_x_i;
                if (upd_i) begin
                    state_d = ST_UPDATE;
                    upd_k_d = 3'd0;
                end else if (wr_val_i) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (walk_last) state_d = ST_IDLE;
            end
            ST_UPDATE: begin
                upd_k_d = upd_k_q + 3'd1;
                if (upd_k_q == 3'd7) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        upd_top_idx = {1'b0, mb_x_q, 3'b000} + {{(TOP_IW-3){1'b0}}, upd_k_q};
    end

    // Read ports: decode valid field, mux storage, register on rd_en_i.
    always_comb begin
        a_cur_mv = cur_q[a_addr_i[5:3]][a_addr_i[2:0]];
        b_cur_mv = cur_q[b_addr_i[6:4]][b_addr_i[2:0]];
`ifdef MVD_MV_BUF_FWD_EN
        if (fill && (walk_y == a_addr_i[5:3]) && (walk_x == a_addr_i[2:0])) a_cur_mv = mv_q;
        if (fill && (walk_y == b_addr_i[6:4]) && (walk_x == b_addr_i[2:0])) b_cur_mv = mv_q;
`endif
        b_top_idx = {1'b0, mb_x_q, 3'b000} + {{(TOP_IW-4){1'b0}}, b_addr_i[3:0]};

        a_rd_vld = 1'b0;
        a_rd_mv  = '0;
        case (a_addr_i[7:6])
            MV_ADDR_NBR: begin
                a_rd_vld = 1'b1;
                a_rd_mv  = left_q[a_addr_i[5:3]];
            end
            MV_ADDR_CUR: begin
                a_rd_vld = 1'b1;
                a_rd_mv  = a_cur_mv;
            end
            default: ;
        endcase

        b_rd_vld = 1'b0;
        b_rd_mv  = '0;
        case (b_addr_i[8:7])
            MV_ADDR_NBR: begin
                b_rd_vld = 1'b1;
                if (b_top_idx < TOP_LIM) b_rd_mv = top_q[b_top_idx[TOP_AW-1:0]];
            end
            MV_ADDR_CUR: begin
                b_rd_vld = 1'b1;
                b_rd_mv  = b_cur_mv;
            end
            default: ;
        endcase

        a_mv_d    = a_mv_q;
        a_valid_d = a_valid_q;
        b_mv_d    = b_mv_q;
        b_valid_d = b_valid_q;
        if (rd_en_i) begin
            a_mv_d    = updating ? '0 : a_rd_mv;
            a_valid_d = updating ? 1'b0 : a_rd_vld;
            b_mv_d    = updating ? '0 : b_rd_mv;
            b_valid_d = updating ? 1'b0 : b_rd_vld;
        end
    end

    assign a_mv_o    = a_mv_q;
    assign a_valid_o = a_valid_q;
    assign b_mv_o    = b_mv_q;
    assign b_valid_o = b_valid_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            mb_x_q    <= '0;
            upd_k_q   <= 3'd0;
            a_mv_q    <= '0;
            a_valid_q <= 1'b0;
            b_mv_q    <= '0;
            b_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mb_x_q    <= mb_x_d;
            upd_k_q   <= upd_k_d;
            a_mv_q    <= a_mv_d;
            a_valid_q <= a_valid_d;
            b_mv_q    <= b_mv_d;
            b_valid_q <= b_valid_d;
        end
    end

    // Storage is not reset; an aborted FILL/UPDATE leaves earlier entries intact.
    always_ff @(posedge clk) begin
        mv_q <= mv_d;
        if (fill) cur_q[walk_y][walk_x] <= mv_q;
        if (updating) begin
            left_q[upd_k_q] <= cur_q[upd_k_q][7];
            if (upd_top_idx < TOP_LIM) top_q[upd_top_idx[TOP_AW-1:0]] <= cur_q[7][upd_k_q];
        end
    end

endmodule

// File: doc/mvd_mv_buf.md
# mvd_mv_buf

Motion-vector neighbour store for the MVD/MC stage. It records the MV of every 8x8 block of the current 64x64 LCU, a left column taken from the previous LCU, and a frame-wide top line. It answers the A (left) and B (top) candidate read addresses produced by `mvd_can_mv_addr`. At LCU end it shifts the current LCU's right column into the left buffer and its bottom row into the top line.

## Interface
Parameters:
- `MV_W`, 20: width of one stored MV word ({mv_x, mv_y}).
- `CTU_X_MAX`, 64: maximum LCU columns per frame; top line holds 8*CTU_X_MAX words.

Ports:
- `clk` in 1: clock.
- `rstn` in 1: asynchronous active-low reset.
- `start_i` in 1: LCU start pulse; latches `mb_x_i`. Legal only in IDLE.
- `mb_x_i` in `PIC_X_WIDTH`: LCU column index.
- `wr_val_i` in 1: PU write request.
- `wr_rdy_o` out 1: write accepted when `wr_val_i && wr_rdy_o`.
- `pos_x_i`, `pos_y_i` in 6 each: PU origin inside the LCU, in pixels.
- `pu_width_i`, `pu_height_i` in 7 each: PU size, in pixels.
- `wr_mv_i` in `MV_W`: MV for the whole PU.
- `wr_done_o` out 1: one-cycle pulse after the last 8x8 entry of a PU is written.
- `upd_i` in 1: LCU end; starts the left/top update. Legal only in IDLE.
- `busy_o` out 1: high in FILL and UPDATE.
- `rd_en_i` in 1: read strobe for both ports.
- `a_addr_i` in 8: {valid[1:0], y[2:0], x[2:0]}.
- `b_addr_i` in 9: {valid[1:0], y[2:0], x[3:0]}.
- `a_mv_o`, `b_mv_o` out `MV_W`: read data.
- `a_valid_o`, `b_valid_o` out 1: candidate available.

## Operation
- Storage:
  - `cur[y][x]`: 8x8 entries.
  - `left[y]`: 8 entries.
  - `top[k]`: 8*CTU_X_MAX entries.
  - Storage flops are not reset.
- Valid-field encoding: 00 = none, 01 = neighbour LCU, 10 = current LCU.
- A port:
  - 01 reads `left[y]`.
  - 10 reads `cur[y][x]`.
- B port:
  - 01 reads `top[{mb_x_r,3'b0} + x]`, with x in 0..15; x of 8..15 is the top-right LCU. y is ignored.
  - 10 reads `cur[y][x[2:0]]`.
- Valid 00 (or 11): `*_valid_o`=0 and `*_mv_o`=0.
- FSM states: IDLE, FILL, UPDATE.
  - IDLE + accepted write -> FILL. Latch bx0=pos_x>>3, by0=pos_y>>3, nbx=max(1,w>>3), nby=max(1,h>>3), and the MV.
  - FILL writes one entry per cycle, raster order with x fastest, starting at (bx0,by0).
  - After nbx*nby writes: `wr_done_o` pulses with the last write, then -> IDLE.
  - IDLE + `upd_i` -> UPDATE, 8 cycles; cycle k copies `left[k]=cur[k][7]` and `top[{mb_x_r,3'b0}+k]=cur[7][k]`, then -> IDLE.
- `wr_rdy_o` = (state==IDLE) && !upd_i. `upd_i` has priority over `wr_val_i` in the same cycle.
- PUs smaller than 8 in either dimension cover one entry; the last write wins.
- Reads during UPDATE are ignored: outputs are forced invalid and zero on the next cycle.
- Reads during FILL are permitted.
- `start_i` and `upd_i` outside IDLE are ignored.

## Timing
- Read latency is 1 cycle: outputs are registered and hold their value when `rd_en_i`=0.
- A PU write occupies nbx*nby cycles in FILL. Range: 1 cycle for 8x8, 64 cycles for 64x64.
- `wr_rdy_o` returns high the cycle after the `wr_done_o` pulse.
- UPDATE takes exactly 8 cycles; `busy_o` is high throughout.
- Reset values:
  - State: IDLE.
  - `wr_rdy_o`=1, `wr_done_o`=0, `busy_o`=0.
  - `a/b_mv_o`=0, `a/b_valid_o`=0.
  - `mb_x_r`=0.
- Reset asserted mid-FILL or mid-UPDATE aborts immediately. Entries already written keep their values; storage is undefined only until first written.

## Configuration
- `MVD_MV_BUF_FWD_EN` defined: a read of a `cur` entry being written in the same cycle returns the new `wr_mv` (write-to-read forwarding, applied to both ports).
- Without it: the same-cycle read returns the old content.

## Structure
- Shared package `mvd_pkg`:
  - `MV_W`.
  - Valid encodings `MV_ADDR_NONE`/`MV_ADDR_NBR`/`MV_ADDR_CUR`.
  - FSM state constants.
  - LCU grid constant (8).
- Sub-module `mvd_mv_buf_walk`: 8x8 block walker.
  - Inputs: bx0/by0/nbx/nby and a start signal.
  - Outputs: the current (x,y) pair and a last-entry flag.
- The top line is a flop array; swapping it for an SRAM must not change the interface.

## Test plan
- Write: 16x16 PU at (16,32), mv=0x12345. The PU is accepted and then 4 FILL cycles run, with `wr_done_o` on the 4th. Read a_addr={10,3'd4,3'd2} -> a_valid_o=1, a_mv_o=0x12345, one cycle after `rd_en_i`.
- Update: after a 64x64 PU with mv=0xABCDE at mb_x=3, `upd_i` -> `busy_o` high for 8 cycles. Then:
  - a_addr={01,3'd5,3'd0} returns 0xABCDE.
  - With mb_x_r=3, b_addr={01,3'd7,4'd2} reads top[26]=0xABCDE.
- Top-right: `top[{4,3'b0}+0]` written via the mb_x=4 update; at mb_x=3, b_addr={01,3'd7,4'd8} returns it.
- Invalid: a_addr={00,...} -> a_valid_o=0, a_mv_o=0. A read issued during UPDATE -> both outputs invalid and zero.
- Collision: write of entry (2,2) and a same-cycle read of it. With `MVD_MV_BUF_FWD_EN` the read returns the new mv; without it, the old mv.
- Reset mid-FILL:
  - Assert `rstn`=0 at FILL cycle 10 of a 32x32 PU -> state IDLE, `wr_rdy_o`=1, all outputs 0.
  - The next 8x8 write completes in 1 cycle.
